router_psum_acc: RTL
====================

# router_psum_acc

Parametrised psum write-back router between the PE array's psum scratchpads and the psum GLB bank. On a request it captures one X_dim × Y_dim tile of partial sums and streams the elements, one per cycle, into consecutive GLB addresses. It supports two modes: overwrite, and accumulate (read-modify-write against the psum already in GLB). It tracks the tile iteration so successive tiles land in successive GLB regions.

## Interface
Parameters:
- DATA_BITWIDTH, 16, width of one psum
- ADDR_BITWIDTH_GLB, 10, GLB address width
- X_dim, 5, psums per PE row
- Y_dim, 3, PE rows per tile
- NUM_ITER, 4, tiles before the iteration counter wraps
- PSUM_LOAD_ADDR, 0, GLB base address of tile 0

Ports (N = X_dim*Y_dim):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- r_data_spad_psum  in  DATA_BITWIDTH*N  tile, element e at bits [(e+1)*DATA_BITWIDTH-1 -: DATA_BITWIDTH], e = row*X_dim + col
- write_psum_ctrl  in  1  start request, sampled in IDLE
- accum_en  in  1  mode select, sampled with the request (1 = accumulate)
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address
- read_en_glb_psum  out  1  GLB read strobe
- w_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB write address
- w_data_glb_psum  out  DATA_BITWIDTH  GLB write data
- write_en_glb_psum  out  1  GLB write strobe
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse when a tile completes

## Operation
- States:
  - IDLE: waits for a request.
  - STREAM: reads and/or writes are in flight.
  - DONE: one cycle, `done` = 1.
- IDLE → STREAM on `write_psum_ctrl` = 1. On the same edge the block:
  - latches `r_data_spad_psum` into a tile buffer;
  - latches `accum_en`;
  - clears the element counters;
  - sets `busy` = 1.
- Address of element e: PSUM_LOAD_ADDR + iter*N + e. The sum wraps modulo 2^ADDR_BITWIDTH_GLB.
- Overwrite mode:
  - Element e is written with `w_data` = buffer[e].
  - `read_en` stays 0.
- Accumulate mode:
  - Element e is first read at its address.
  - It is then written with buffer[e] + `r_data_glb_psum`. The add wraps modulo 2^DATA_BITWIDTH, with no saturation.
  - Reads and writes are pipelined: the read of element e+2 overlaps the write of element e. The GLB must be dual-port; read and write addresses always differ.
- STREAM → DONE after the write of element N-1 has been driven.
- DONE:
  - `iter` increments, wrapping NUM_ITER-1 → 0.
  - `busy` = 0, then return to IDLE.
- `write_psum_ctrl` while not in IDLE is ignored; the request is not queued.
- Reset:
  - `iter` = 0, state = IDLE.
  - All strobes, `busy` and `done` = 0.
  - All addresses = PSUM_LOAD_ADDR, `w_data_glb_psum` = 0.
  - Reset mid-tile abandons the tile immediately, with no further GLB strobes.
- Outside active cycles, the strobes are 0 and the address/data outputs hold their last values.

## Timing
- E0 is the edge that samples the request; Cj is the cycle following edge E0+j. All outputs are registered.
- The GLB read is synchronous: data for a read strobed in cycle Cj is valid in Cj+1.
- Overwrite mode:
  - The write of element e is driven in C(1+e).
  - `done` is high in C(N+1).
  - `busy` is high C1..C(N+1) and 0 from C(N+2).
- Accumulate mode:
  - The read of element e is driven in C(1+e), for e < N.
  - The write of element e is driven in C(3+e).
  - `done` is high in C(N+3).
  - `busy` is high C1..C(N+3).
- A new request is accepted no earlier than the edge ending the DONE cycle. The first write of the new tile follows at the earliest 2 cycles after `done`.

## Test plan
- Reset, then overwrite with element e = e+1 (N = 15), iter 0:
  - writes addr 0..14, data 1..15, in C1..C15;
  - `done` in C16, `read_en` never 1.
- Second overwrite tile: writes go to addr 15..29.
  - After NUM_ITER = 4 tiles, the fifth tile writes addr 0..14 (iter wrap).
- Accumulate with GLB preloaded to 100 at addr 0..14 and buffer e = e+1:
  - reads addr e in C(1+e);
  - writes 101..115 in C3..C17;
  - `done` in C18.
- Accumulate wrap: GLB = 0xFFFF, buffer = 2 → written 0x0001.
- `write_psum_ctrl` held high through a tile:
  - exactly one tile is written;
  - the next tile starts only after `done`;
  - with changing spad data mid-tile, the written data stays equal to the captured tile.
- Reset asserted in C5 of an accumulate tile:
  - next cycle all strobes, `busy` and `done` = 0;
  - a following request writes from addr PSUM_LOAD_ADDR (iter 0).

Source files
------------

// File: rtl/router_psum_acc_if.sv
// Psum write-back bundle: spad tile and request from the PE side,
// GLB read/write ports, and status toward the controller.
interface router_psum_acc_if #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int N                 = 15
);
  logic [DATA_BITWIDTH*N-1:0]   r_data_spad_psum;
  logic                         write_psum_ctrl;
  logic                         accum_en;
  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum;
  logic                         read_en_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum;
  logic                         write_en_glb_psum;
  logic                         busy;
  logic                         done;

  modport master (
    output r_data_spad_psum, write_psum_ctrl, accum_en, r_data_glb_psum,
    input  r_addr_glb_psum, read_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
    input  write_en_glb_psum, busy, done
  );

  modport slave (
    input  r_data_spad_psum, write_psum_ctrl, accum_en, r_data_glb_psum,
    output r_addr_glb_psum, read_en_glb_psum, w_addr_glb_psum, w_data_glb_psum,
    output write_en_glb_psum, busy, done
  );
endinterface

// File: rtl/router_psum_acc.sv
// Captures one X_dim*Y_dim psum tile and streams it into consecutive GLB addresses,
// overwriting or read-modify-writing; first write 1 cycle (overwrite) or 3 cycles (accumulate) after the request.
module router_psum_acc #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int X_dim             = 5,
  parameter int Y_dim             = 3,
  parameter int NUM_ITER          = 4,
  parameter int PSUM_LOAD_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  router_psum_acc_if.slave  bus
);
  localparam int N      = X_dim * Y_dim;
  localparam int DW     = DATA_BITWIDTH;
  localparam int AW     = ADDR_BITWIDTH_GLB;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int ITER_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NUM_ITER - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state, state_nxt;
  logic [DW*N-1:0]    tile_buf;
  logic               accum_q;
  logic [CNT_W-1:0]   rd_cnt, wr_cnt;
  logic [ITER_W-1:0]  iter;
  logic               rd_pend;
  logic [AW-1:0]      base_addr;
  logic [DW-1:0]      wr_elem;

  logic [AW-1:0]      r_addr_q, w_addr_q;
  logic [DW-1:0]      w_data_q;
  logic               re_q, we_q, busy_q, done_q;

  // iter only changes in DONE, so the tile base is stable for the whole stream
  assign base_addr = AW'(PSUM_LOAD_ADDR) + AW'(iter) * AW'(N);
  assign wr_elem   = tile_buf[int'(wr_cnt)*DW +: DW];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.write_psum_ctrl) state_nxt = STREAM;
      STREAM:  if (wr_cnt == N_CNT)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tile_buf <= '0;
      accum_q  <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      iter     <= '0;
      rd_pend  <= 1'b0;
      r_addr_q <= AW'(PSUM_LOAD_ADDR);
      w_addr_q <= AW'(PSUM_LOAD_ADDR);
      w_data_q <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      // GLB read data arrives the cycle after the strobe; rd_pend marks that cycle
      rd_pend <= re_q;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      unique case (state)
        IDLE: begin
          if (bus.write_psum_ctrl) begin
            tile_buf <= bus.r_data_spad_psum;
            accum_q  <= bus.accum_en;
            if (bus.accum_en) begin
              re_q     <= 1'b1;
              r_addr_q <= base_addr;
              rd_cnt   <= CNT_W'(1);
              wr_cnt   <= '0;
            end else begin
              we_q     <= 1'b1;
              w_addr_q <= base_addr;
              w_data_q <= bus.r_data_spad_psum[DW-1:0];
              wr_cnt   <= CNT_W'(1);
              rd_cnt   <= '0;
            end
          end
        end
        STREAM: begin
          if (accum_q) begin
            if (rd_cnt != N_CNT) begin
              re_q     <= 1'b1;
              r_addr_q <= base_addr + AW'(rd_cnt);
              rd_cnt   <= rd_cnt + 1'b1;
            end
            if (rd_pend) begin
              we_q     <= 1'b1;
              w_addr_q <= base_addr + AW'(wr_cnt);
              w_data_q <= wr_elem + bus.r_data_glb_psum;
              wr_cnt   <= wr_cnt + 1'b1;
            end
          end else if (wr_cnt != N_CNT) begin
            we_q     <= 1'b1;
            w_addr_q <= base_addr + AW'(wr_cnt);
            w_data_q <= wr_elem;
            wr_cnt   <= wr_cnt + 1'b1;
          end
        end
        DONE: iter <= (iter == ITER_MAX) ? '0 : iter + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.r_addr_glb_psum   = r_addr_q;
  assign bus.read_en_glb_psum  = re_q;
  assign bus.w_addr_glb_psum   = w_addr_q;
  assign bus.w_data_glb_psum   = w_data_q;
  assign bus.write_en_glb_psum = we_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
endmodule
